// File: rtl/ysyx_22040632_icache.sv
// ysyx_22040632_icache: direct-mapped 128-bit-line instruction cache with an AXI read refill port, uncached bypass, fence.i invalidation and hit/miss counters
module ysyx_22040632_icache #(
  parameter int NSET   = 16,
  parameter int LINE_B = 16
) (
  input  logic         i_clk,
  input  logic         i_rrst,
  input  logic         i_fence_sig,
  input  logic         i_if2ic_valid,
  input  logic [31:0]  i_if2ic_pc,
  input  logic         i_if2ic_uncacheable,
  output logic         o_if2ic_ready,
  output logic [127:0] o_if2ic_inst,
  output logic         o_arvalid,
  input  logic         i_arready,
  output logic [31:0]  o_araddr,
  output logic [7:0]   o_arlen,
  output logic [2:0]   o_arsize,
  output logic [1:0]   o_arburst,
  input  logic         i_rvalid,
  output logic         o_rready,
  input  logic [63:0]  i_rdata,
  input  logic [1:0]   i_rresp,
  input  logic         i_rlast,
  output logic [31:0]  o_hit_cnt,
  output logic [31:0]  o_miss_cnt
);
  localparam int OW = $clog2(LINE_B);
  localparam int IW = $clog2(NSET);
  localparam int TW = 32 - OW - IW;
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_AR, S_R, S_RESP} state_t;
  state_t r_state, w_next;
  logic [31:2] r_req_pc;
  logic r_req_unc, r_drop, r_err;
  logic [NSET-1:0] r_valid;
  logic [TW-1:0] r_tag [NSET];
  logic [127:0] r_data [NSET];
  logic [127:0] r_fill, r_inst, w_resp_data;
  logic [31:0] r_hit_cnt, r_miss_cnt;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic w_same, w_hit, w_hit_go, w_miss_go, w_install, w_unused;
  assign w_unused = ^i_if2ic_pc[1:0];
  assign w_idx = r_req_pc[OW+IW-1:OW];
  assign w_tag = r_req_pc[31:OW+IW];
  // the IFU may retract or redirect a held request; a response is only given to the same word
  assign w_same = i_if2ic_valid && (i_if2ic_pc[31:2] == r_req_pc[31:2]);
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !r_req_unc;
  assign w_hit_go = (r_state == S_LOOKUP) && w_same && w_hit;
  assign w_miss_go = (r_state == S_LOOKUP) && w_same && !w_hit && !r_req_unc;
  // any error beat, a fence during the fill, or a fence this very cycle keeps the line out
  assign w_install = (r_state == S_R) && i_rvalid && i_rlast && !r_req_unc && !r_drop && !r_err && (i_rresp == 2'b00) && !i_fence_sig;
  always_comb begin
    w_next = r_state;
    o_if2ic_ready = 1'b0;
    case (r_state)
      S_IDLE:   w_next = i_if2ic_valid ? S_LOOKUP : S_IDLE;
      S_LOOKUP: begin
        o_if2ic_ready = w_same && w_hit;
        w_next = (!w_same || w_hit) ? S_IDLE : S_AR;
      end
      S_AR:     w_next = i_arready ? S_R : S_AR;
      S_R:      w_next = (i_rvalid && i_rlast) ? S_RESP : S_R;
      S_RESP:   begin
        o_if2ic_ready = w_same;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end
  assign w_resp_data = (r_state == S_LOOKUP) ? r_data[w_idx] : r_fill;
  assign o_if2ic_inst = o_if2ic_ready ? w_resp_data : r_inst;
  assign o_arvalid = r_state == S_AR;
  assign o_araddr = r_req_unc ? {r_req_pc[31:2], 2'b00} : {r_req_pc[31:OW], {OW{1'b0}}};
  assign o_arlen = r_req_unc ? 8'd0 : 8'd1;
  assign o_arsize = r_req_unc ? 3'd2 : 3'd3;
  assign o_arburst = 2'b01;
  assign o_rready = r_state == S_R;
  assign o_hit_cnt = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
  always_ff @(posedge i_clk or posedge i_rrst) begin
    if (i_rrst) begin
      r_state <= S_IDLE;
      r_req_pc <= '0;
      r_req_unc <= 1'b0;
      r_drop <= 1'b0;
      r_err <= 1'b0;
      r_valid <= '0;
      r_fill <= '0;
      r_inst <= '0;
      r_hit_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_if2ic_valid) begin
        r_req_pc <= i_if2ic_pc[31:2];
        r_req_unc <= i_if2ic_uncacheable;
      end
      if (i_fence_sig) r_valid <= '0;
      else if (w_install) r_valid[w_idx] <= 1'b1;
      if (w_next == S_IDLE) r_drop <= 1'b0;
      else if (i_fence_sig && (r_state == S_AR || r_state == S_R)) r_drop <= 1'b1;
      if (r_state == S_IDLE) r_err <= 1'b0;
      else if (r_state == S_R && i_rvalid && i_rresp != 2'b00) r_err <= 1'b1;
      if (r_state == S_R && i_rvalid)
        r_fill <= r_req_unc ? {64'd0, i_rdata} : i_rlast ? {i_rdata, r_fill[63:0]} : {r_fill[127:64], i_rdata};
      if (o_if2ic_ready) r_inst <= w_resp_data;
      if (w_hit_go && r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss_go && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_install) begin
      r_tag[w_idx] <= w_tag;
      r_data[w_idx] <= {i_rdata, r_fill[63:0]};
    end
  end
endmodule

// File: doc/ysyx_22040632_icache.md
YSYX_22040632_ICACHE -- requirements
Module: ysyx_22040632_icache

Interface
REQ-001 SHALL have parameter NSET, default 16, number of direct-mapped lines (power of two, 2..64).
REQ-002 SHALL have parameter LINE_B, default 16, line size in bytes (fixed; matches IFU 128-bit prefetch buffer).
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rrst  in  1  reset, asynchronous and active-high.
REQ-005 fence_sig  in  1  invalidate all lines (fence.i).
REQ-006 if2ic.valid  in  1  IFU fetch request; held until ready.
REQ-007 if2ic.pc  in  32  fetch address.
REQ-008 if2ic.uncacheable  in  1  bypass cache for this request.
REQ-009 if2ic.ready  out  1  one-cycle response pulse; inst valid this cycle.
REQ-010 if2ic.inst  out  128  cacheable: full line; uncacheable: 64-bit bus beat in [63:0], [127:64]=0.
REQ-011 arvalid/arready  out/in  1/1  AXI read address handshake.
REQ-012 araddr  out  32; arlen  out  8; arsize  out  3; arburst  out  2.
REQ-013 rvalid/rready  in/out  1/1; rdata  in  64; rresp  in  2; rlast  in  1.
REQ-014 hit_cnt, miss_cnt  out  32 each  saturating performance counters.

Function
REQ-015 SHALL implement FSM IDLE, LOOKUP, AR, R, RESP.
REQ-016 IDLE: on valid, SHALL latch pc and uncacheable into req registers, go LOOKUP; otherwise stay.
REQ-017 LOOKUP: index=req_pc[log2(NSET)+3:4], tag=req_pc[31:4+log2(NSET)]; hit = valid bit & tag equal & !req_unc.
REQ-018 LOOKUP hit: SHALL assert ready combinationally with inst=stored line, increment hit_cnt, return IDLE; hit latency = ready in second cycle after valid first sampled.
REQ-019 LOOKUP miss or uncacheable: SHALL go AR; miss_cnt increments only for cacheable misses.
REQ-020 AR cacheable: araddr={req_pc[31:4],4'b0}, arlen=1, arsize=3, arburst=2'b01; arvalid held until arready, then R.
REQ-021 AR uncacheable: araddr={req_pc[31:2],2'b0}, arlen=0, arsize=2, arburst=2'b01.
REQ-022 arvalid and araddr SHALL stay stable from assertion to arready (AXI rule).
REQ-023 R: rready=1; cacheable beat0 -> line[63:0], beat1 (rlast) -> line[127:64]; uncacheable single beat -> rdata into fill buffer [63:0], upper zero.
REQ-024 On rlast, cacheable: SHALL write line, tag, set valid bit, unless drop flag or any rresp!=0 in burst; then RESP.
REQ-025 Uncacheable data SHALL never be installed in the array.
REQ-026 RESP: ready=1 for exactly one cycle, inst=fill buffer, then IDLE.
REQ-027 LOOKUP/RESP: if valid low or pc[31:2] != req_pc[31:2], SHALL suppress ready and return IDLE (install still performed).
REQ-028 if2ic.inst SHALL hold its last driven value from the ready cycle until the next ready pulse (IFU samples it one cycle late).
REQ-029 fence_sig: SHALL clear all valid bits in the same cycle; if in AR or R, SHALL set drop flag so the pending fill is returned but not installed; drop clears on entering IDLE.
REQ-030 fence_sig concurrent with install: fence wins; line stays invalid.
REQ-031 Counters SHALL saturate at 32'hFFFF_FFFF, no wrap.
REQ-032 No new request SHALL be accepted while not in IDLE; no outstanding AR beyond one.

Reset
REQ-033 On rrst: state=IDLE, all valid bits 0, drop=0, ready=0, inst=0, arvalid=0, rready=0, counters=0; tag/data arrays need not be cleared.
REQ-034 rrst mid-burst SHALL abort immediately; stale R beats after reset release are not expected (bus reset shared).

Verification
REQ-035 Cold fetch pc=0x8000_0000 cacheable, rdata 0x1111..,0x2222.. -> araddr 0x8000_0000 arlen 1, ready with inst={0x2222..,0x1111..}, miss_cnt=1.
REQ-036 Refetch pc=0x8000_0008 -> no AR, ready 2nd cycle, same line, hit_cnt=1.
REQ-037 Uncacheable pc=0x3000_0004 -> araddr 0x3000_0004 arlen 0 arsize 2, inst[127:64]=0, refetch misses again, miss_cnt unchanged.
REQ-038 fence_sig during beat0 of fill for 0x8000_0040 -> response delivered, next fetch of 0x8000_0040 issues AR again.
REQ-039 Conflict: fill 0x8000_0000 then 0x8000_0100 (same index, NSET=16) then 0x8000_0000 -> third access misses.
REQ-040 rresp=2'b10 on beat1 -> ready still pulsed, line not installed, refetch misses.
